word_serializer: RTL and testbench

- Producer end of the bit-serial word bus used by the SHA-256 datapath stages.
- Accepts parallel W-bit words over a valid/ready handshake and drives the bus signals `bclk`, `counter` and `ser_out` MSB-first.
- Captures the returning serial stream `ser_in` back into parallel words on the same bit timing.
- Sits between the parallel message/state registers and the chain of bit-serial stages.

---
 rtl/bit_serial_pkg.sv | 16 +
 rtl/bclk_gen.sv | 49 ++++
 rtl/word_serializer.sv | 126 ++++++++++++
 tb/tb_word_serializer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_pkg.sv
// Shared types and constants for the bit-serial word bus.
package bit_serial_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned W_WORD = 32;

  // Width of a bit index within a w-bit word.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/bclk_gen.sv
// Phase timer and bit-clock register; each bclk half-period lasts DIV clk cycles.
module bclk_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic bclk_o,
  output logic rise_now_c,
  output logic fall_now_c,
  output logic last_cycle_c
);

  localparam int unsigned TW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [TW-1:0] timer_q, timer_d;
  logic          bclk_q, bclk_d;

  // Strobes announce what bclk does on the coming clk edge.
  assign last_cycle_c = en_i && (timer_q == TW'(DIV - 1));
  assign rise_now_c   = last_cycle_c && !bclk_q;
  assign fall_now_c   = last_cycle_c && bclk_q;
  assign bclk_o       = bclk_q;

  always_comb begin
    timer_d = timer_q;
    bclk_d  = bclk_q;
    if (!en_i) begin
      timer_d = '0;
      bclk_d  = 1'b0;
    end else if (last_cycle_c) begin
      timer_d = '0;
      bclk_d  = !bclk_q;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q <= '0;
      bclk_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      bclk_q  <= bclk_d;
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Producer end of the bit-serial word bus: parallel words out MSB-first on
// ser_out, returning ser_in captured back into parallel words.
module word_serializer
  import bit_serial_pkg::*;
#(
  parameter  int unsigned W   = W_WORD,
  parameter  int unsigned DIV = 2,
  localparam int unsigned CW  = cnt_width(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic          bclk,
  output logic [CW-1:0] counter,
  output logic          ser_out,
  input  logic          ser_in,
  output logic [W-1:0]  rx_data,
  output logic          rx_valid,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [CW-1:0] counter_q, counter_d;
  logic [W-1:0]  tx_shift_q, tx_shift_d;
  logic [W-1:0]  rx_shift_q, rx_shift_d;
  logic [W-1:0]  rx_data_q, rx_data_d;
  logic          rx_pend_q, rx_pend_d;
  logic          rx_valid_q, rx_valid_d;

  logic run_c, rise_c, fall_c, last_c, last_bit_c, accept_c;

  assign run_c = (state_q == RUN);

  bclk_gen #(
    .DIV (DIV)
  ) u_bclk_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (run_c),
    .bclk_o       (bclk),
    .rise_now_c   (rise_c),
    .fall_now_c   (fall_c),
    .last_cycle_c (last_c)
  );

  // Ready in IDLE, or in the final clk of the last bit's high phase.
  assign last_bit_c = (counter_q == CW'(W - 1));
  assign tx_ready   = rst_n && (!run_c || (last_c && bclk && last_bit_c));
  assign accept_c   = tx_valid && tx_ready;

  assign counter  = counter_q;
  assign ser_out  = tx_shift_q[W-1];
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = run_c;

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_pend_d  = 1'b0;
    rx_valid_d = 1'b0;

    // Publish the captured word one clk after its last bit was sampled.
    if (rx_pend_q) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
    end

    if (rise_c) begin
      rx_shift_d = {rx_shift_q[W-2:0], ser_in};
      rx_pend_d  = last_bit_c;
    end

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d    = RUN;
          counter_d  = '0;
          tx_shift_d = tx_data;
        end
      end
      RUN: begin
        if (fall_c) begin
          if (!last_bit_c) begin
            counter_d  = counter_q + CW'(1);
            tx_shift_d = tx_shift_q << 1;
          end else if (accept_c) begin
            counter_d  = '0;
            tx_shift_d = tx_data;
          end else begin
            state_d    = IDLE;
            counter_d  = '0;
            tx_shift_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      counter_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_pend_q  <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_pend_q  <= rx_pend_d;
      rx_valid_q <= rx_valid_d;
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: W=32/DIV=2 instance against a cycle model, plus a W=8/DIV=3 instance.
module tb_word_serializer;

  localparam int AD = 2;
  localparam int AW = 32;
  localparam int AP = 2 * AD * AW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] a_tx_data;
  logic        a_tx_valid, a_tx_ready, a_bclk, a_ser_out, a_ser_in, a_rx_valid, a_busy;
  logic [4:0]  a_counter;
  logic [31:0] a_rx_data;
  bit          a_force = 1'b0;
  assign a_ser_in = a_force ? 1'b1 : a_ser_out;

  word_serializer #(.W(32), .DIV(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(a_tx_data), .tx_valid(a_tx_valid),
    .tx_ready(a_tx_ready), .bclk(a_bclk), .counter(a_counter), .ser_out(a_ser_out),
    .ser_in(a_ser_in), .rx_data(a_rx_data), .rx_valid(a_rx_valid), .busy(a_busy)
  );

  logic [7:0] b_tx_data, b_rx_data;
  logic       b_tx_valid, b_tx_ready, b_bclk, b_ser_out, b_rx_valid, b_busy;
  logic [2:0] b_counter;

  word_serializer #(.W(8), .DIV(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(b_tx_data), .tx_valid(b_tx_valid),
    .tx_ready(b_tx_ready), .bclk(b_bclk), .counter(b_counter), .ser_out(b_ser_out),
    .ser_in(b_ser_out), .rx_data(b_rx_data), .rx_valid(b_rx_valid), .busy(b_busy)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: word position t counts clk cycles from the one after acceptance.
  bit          chk_on = 1'b0;
  bit          m_active = 1'b0;
  int          m_t = 0;
  logic [31:0] m_word = '0;
  bit          m_force = 1'b0;
  bit          m_rxv = 1'b0;
  logic [31:0] m_rxd = '0;
  logic        e_bclk, e_ser, e_ready, m_acc;
  logic [4:0]  e_cnt;
  logic [41:0] act_v, exp_v;

  initial forever begin
    @(negedge clk);
    e_bclk  = m_active && ((m_t % (2 * AD)) >= AD);
    e_cnt   = m_active ? 5'(m_t / (2 * AD)) : 5'd0;
    e_ser   = m_active ? m_word[31 - (m_t / (2 * AD))] : 1'b0;
    e_ready = rst_n && (!m_active || (m_t == AP - 1));
    act_v = {a_bclk, a_counter, a_ser_out, a_tx_ready, a_busy, a_rx_valid, a_rx_data};
    exp_v = {e_bclk, e_cnt, e_ser, e_ready, 1'(m_active), 1'(m_rxv), m_rxd};
    if (chk_on) check("a_cycle", 64'(act_v), 64'(exp_v));
    if (!rst_n) begin
      m_active = 1'b0; m_t = 0; m_rxv = 1'b0; m_rxd = '0;
    end else begin
      m_acc = a_tx_valid && e_ready;
      m_rxv = m_active && (m_t == AP - AD);
      if (m_rxv) m_rxd = m_force ? 32'hFFFF_FFFF : m_word;
      if (m_active) begin
        m_t++;
        if (m_t == AP) begin
          if (m_acc) begin m_t = 0; m_word = a_tx_data; m_force = a_force; end
          else m_active = 1'b0;
        end
      end else if (m_acc) begin
        m_active = 1'b1; m_t = 0; m_word = a_tx_data; m_force = a_force;
      end
    end
  end

  logic [31:0] rxq[$];
  initial forever begin
    @(negedge clk);
    if (a_rx_valid) rxq.push_back(a_rx_data);
  end

  // Offer w until accepted; returns one clk into the new word.
  task automatic a_send(input logic [31:0] w, output int waited, output logic [4:0] cnt_at);
    bit ok;
    ok = 1'b0; waited = 0; cnt_at = '0;
    a_tx_data = w; a_tx_valid = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (a_tx_ready) begin ok = 1'b1; cnt_at = a_counter; end
      else waited++;
      @(posedge clk); #1;
    end
    check("a_accept", 64'(ok), 64'd1);
  endtask

  task automatic a_wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!a_busy) break;
    end
    check("a_idle_reached", 64'(a_busy), 64'd0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] word;
    bit          force1;
    logic [31:0] exp_rx;
  } vec_t;
  vec_t tbl[4];

  int          wt, lat, nbad, nrx, t0, t1, first_rise, last_rise, nrise, badsp, badchg;
  logic [4:0]  ca;
  logic [31:0] got;
  logic [2:0]  lowseq;
  bit          chain;
  logic        rb[52], rs[52];
  logic [2:0]  rc[52];
  logic [7:0]  bits, b_got;

  initial begin
    tbl[0] = '{32'h8000_0001, 1'b0, 32'h8000_0001};
    tbl[1] = '{32'h7FFF_FFFE, 1'b0, 32'h7FFF_FFFE};
    tbl[2] = '{32'h1234_5678, 1'b1, 32'hFFFF_FFFF};
    tbl[3] = '{32'hA5C3_0F96, 1'b0, 32'hA5C3_0F96};

    rst_n = 1'b0; a_tx_valid = 1'b0; a_tx_data = '0; b_tx_valid = 1'b0; b_tx_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("a_ready_in_reset", 64'(a_tx_ready), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    check("a_reset_state", 64'({a_bclk, a_counter, a_ser_out, a_rx_data, a_rx_valid, a_busy, a_tx_ready}), 64'd1);
    @(posedge clk); #1;

    // Single words from the table: rx content and rx latency.
    for (int k = 0; k < 4; k++) begin
      a_force = tbl[k].force1;
      a_send(tbl[k].word, wt, ca);
      a_tx_valid = 1'b0;
      lat = -1; got = '0;
      for (int t = 0; t < 200 && lat < 0; t++) begin
        @(negedge clk);
        if (a_rx_valid) begin lat = t; got = a_rx_data; end
      end
      check("tbl_rx_data", 64'(got), 64'(tbl[k].exp_rx));
      check("tbl_rx_latency", 64'(lat), 64'd127);
      a_wait_idle();
      a_force = 1'b0;
    end

    // Back-to-back words with tx_valid held.
    rxq.delete();
    a_send(32'hDEAD_BEEF, wt, ca);
    t0 = cyc;
    a_send(32'h1234_5678, wt, ca);
    t1 = cyc;
    check("b2b_gap", 64'(t1 - t0), 64'd128);
    check("b2b_ready_wait", 64'(wt), 64'd127);
    check("b2b_cnt_at_wrap", 64'(ca), 64'd31);
    a_tx_valid = 1'b0;
    lowseq = '0; nbad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lowseq = {lowseq[1:0], a_bclk};
      if (a_tx_ready || (i < 2 && a_counter != 5'd0)) nbad++;
    end
    check("b2b_wrap_low_phase", 64'(lowseq), 64'b001);
    check("b2b_ready_single", 64'(nbad), 64'd0);
    @(posedge clk); #1;
    a_wait_idle();
    repeat (2) @(posedge clk); #1;
    check("b2b_rx_count", 64'(rxq.size()), 64'd2);
    if (rxq.size() == 2) begin
      check("b2b_rx_first", 64'(rxq[0]), 64'hDEAD_BEEF);
      check("b2b_rx_second", 64'(rxq[1]), 64'h1234_5678);
    end

    // Idle hold, then restart with a full low phase.
    nbad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_bclk || a_counter != 5'd0 || a_busy || a_ser_out) nbad++;
    end
    check("idle_hold", 64'(nbad), 64'd0);
    @(posedge clk); #1;
    a_send(32'h0F0F_0F0F, wt, ca);
    a_tx_valid = 1'b0;
    lowseq = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lowseq = {lowseq[1:0], a_bclk};
    end
    check("restart_low_phase", 64'(lowseq), 64'b001);
    @(posedge clk); #1;
    a_wait_idle();

    // Reset pulse during bit 10 aborts the word.
    a_send(32'hCAFE_F00D, wt, ca);
    a_tx_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_counter == 5'd10) break;
    end
    check("rst_reached_bit10", 64'(a_counter), 64'd10);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_outputs", 64'({a_bclk, a_counter, a_ser_out, a_rx_data, a_rx_valid, a_busy, a_tx_ready}), 64'd1);
    nrx = 0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (a_rx_valid) nrx++;
    end
    check("rst_no_rx", 64'(nrx), 64'd0);
    @(posedge clk); #1;

    // Random words, gaps, chaining and forced ser_in; the cycle model checks them.
    chain = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (!chain) begin
        a_wait_idle();
        a_force = ($urandom_range(0, 3) == 0);
        repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
      end
      a_send($urandom, wt, ca);
      chain = (n < 11) && ($urandom_range(0, 1) == 1);
      if (!chain) a_tx_valid = 1'b0;
    end
    a_wait_idle();
    a_force = 1'b0;

    // W=8, DIV=3 instance, loopback, 0xA5.
    b_tx_data = 8'hA5; b_tx_valid = 1'b1;
    @(negedge clk);
    check("b_ready_idle", 64'(b_tx_ready), 64'd1);
    @(posedge clk); #1 b_tx_valid = 1'b0;
    nrx = 0; b_got = '0;
    for (int i = 0; i < 52; i++) begin
      @(negedge clk);
      rb[i] = b_bclk; rc[i] = b_counter; rs[i] = b_ser_out;
      if (b_rx_valid) begin nrx++; b_got = b_rx_data; end
    end
    bits = '0; nrise = 0; badsp = 0; badchg = 0; first_rise = -1; last_rise = -1;
    for (int i = 1; i < 52; i++) begin
      if (rb[i] && !rb[i-1]) begin
        bits = {bits[6:0], rs[i]};
        nrise++;
        if (first_rise < 0) first_rise = i;
        if (last_rise >= 0 && (i - last_rise) != 6) badsp++;
        last_rise = i;
      end
      if ((rs[i] != rs[i-1] || rc[i] != rc[i-1]) && !(rb[i-1] && !rb[i])) badchg++;
    end
    check("b_ser_bits", 64'(bits), 64'hA5);
    check("b_rise_count", 64'(nrise), 64'd8);
    check("b_first_rise", 64'(first_rise), 64'd3);
    check("b_bit_period", 64'(badsp), 64'd0);
    check("b_change_on_fall", 64'(badchg), 64'd0);
    check("b_rx_pulses", 64'(nrx), 64'd1);
    check("b_rx_data", 64'(b_got), 64'hA5);
    check("b_idle_end", 64'({b_busy, b_bclk, b_counter, b_ser_out}), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
